hazard_sequencer: RTL

Pipeline hazard and stall sequencer for the 5-stage RISC-V core; sits beside the decode-stage control unit and drives the write-enable, flush and bubble strobes of the PC and pipeline registers. It detects load-use hazards (ID vs. EX load), applies control-flow flushes for taken branches, JAL and JALR resolved in EX, and freezes the whole pipeline while data memory is not ready. A wait watchdog escalates a stuck memory access to a sticky bus-error state.

---
 rtl/hazard_sequencer_if.sv | 37 +++
 rtl/hazard_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer_if.sv
// Hazard sequencer pipeline-side bundle: hazard sources in, PC/pipeline-register strobes and counters out.
interface hazard_sequencer_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic [4:0]           id_rs1_i;
    logic [4:0]           id_rs2_i;
    logic                 id_use_rs1_i;
    logic                 id_use_rs2_i;
    logic [4:0]           ex_rd_i;
    logic                 ex_mem_read_i;
    logic                 ex_redirect_i;
    logic                 mem_req_i;
    logic                 mem_ready_i;
    logic                 pc_write_o;
    logic                 if_id_write_o;
    logic                 if_id_flush_o;
    logic                 id_ex_bubble_o;
    logic                 freeze_o;
    logic                 bus_error_o;
    logic [CNT_WIDTH-1:0] stall_cnt_o;
    logic [CNT_WIDTH-1:0] flush_cnt_o;
    logic [CNT_WIDTH-1:0] freeze_cnt_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               ex_rd_i, ex_mem_read_i, ex_redirect_i, mem_req_i, mem_ready_i,
        input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
               freeze_o, bus_error_o, stall_cnt_o, flush_cnt_o, freeze_cnt_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               ex_rd_i, ex_mem_read_i, ex_redirect_i, mem_req_i, mem_ready_i,
        output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
               freeze_o, bus_error_o, stall_cnt_o, flush_cnt_o, freeze_cnt_o
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Load-use / redirect / memory-freeze sequencer with a wait watchdog for a 5-stage RISC-V core.
// Define HZD_PERF_CNT_EN to build the saturating stall/flush/freeze performance counters.
module hazard_sequencer #(
    parameter int unsigned MAX_WAIT  = 16,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    hazard_sequencer_if.slave bus
);
    localparam int unsigned WW = $clog2(MAX_WAIT) + 1;

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERROR} state_e;

    state_e        state_q, state_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          bus_error_q, bus_error_d;

    logic mem_stall;
    logic load_use;
    logic pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze;

    always_comb begin
        mem_stall = bus.mem_req_i & ~bus.mem_ready_i;
        load_use  = bus.ex_mem_read_i & (bus.ex_rd_i != 5'd0) &
                    ((bus.id_use_rs1_i & (bus.id_rs1_i == bus.ex_rd_i)) |
                     (bus.id_use_rs2_i & (bus.id_rs2_i == bus.ex_rd_i)));

        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        freeze       = 1'b0;

        // Reset forces the idle strobes; otherwise priority is error, freeze, redirect, load-use.
        if (reset) begin
            pc_write = 1'b1;
        end else if (state_q == S_ERROR || mem_stall) begin
            freeze      = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (bus.ex_redirect_i) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        bus_error_d = bus_error_q;
        case (state_q)
            S_RUN: begin
                if (mem_stall) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = WW'(1);
                end
            end
            S_WAIT: begin
                if (!mem_stall) begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WW'(MAX_WAIT - 1)) begin
                    state_d     = S_ERROR;
                    bus_error_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d    = S_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign bus.pc_write_o     = pc_write;
    assign bus.if_id_write_o  = if_id_write;
    assign bus.if_id_flush_o  = if_id_flush;
    assign bus.id_ex_bubble_o = id_ex_bubble;
    assign bus.freeze_o       = freeze;
    assign bus.bus_error_o    = bus_error_q;

`ifdef HZD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_WIDTH-1:0] freeze_cnt_q, freeze_cnt_d;

    // A bubble without a flush is exactly a load-use stall.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        freeze_cnt_d = freeze_cnt_q;
        if (id_ex_bubble && !if_id_flush && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        if (if_id_flush && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        if (freeze && freeze_cnt_q != '1)
            freeze_cnt_d = freeze_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign bus.stall_cnt_o  = stall_cnt_q;
    assign bus.flush_cnt_o  = flush_cnt_q;
    assign bus.freeze_cnt_o = freeze_cnt_q;
`else
    assign bus.stall_cnt_o  = CNT_WIDTH'(0);
    assign bus.flush_cnt_o  = CNT_WIDTH'(0);
    assign bus.freeze_cnt_o = CNT_WIDTH'(0);
`endif
endmodule
